mole_round_ctrl: RTL and testbench
==================================

# mole_round_ctrl

Round sequencer for the whack-a-mole game. Takes the free-running 3-bit LFSR value, one-cycle tick pulses and the 8 player buttons. Decides when and where each mole appears, detects hits and misses, and keeps the 6-bit score that feeds the seven-segment score display. Sits between the LFSR, the LED bank and the score display inside the game top level, and replaces the ad-hoc LED/score logic.

## Interface
- `SHOW_TICKS`, default 8: ticks a mole stays lit (1..255).
- `GAP_TICKS`, default 2: dark ticks between moles (1..255).
- `MISS_LIMIT`, default 3: misses that end the game (1..7).
- `ROUND_MOLES`, default 32: moles per game (1..63).
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `tick` in 1: one-cycle pulse from the prescaler; time base for all tick counters.
- `start` in 1: level; sampled only in IDLE/OVER.
- `rnd` in 3: LFSR output, sampled in LOAD.
- `button` in 8: player buttons, already synchronised, active-high level.
- `mole_led` out 8: LED drive.
- `score` out 6: hit count, to the score display.
- `misses` out 3: miss count.
- `game_over` out 1: high in OVER.
- `busy` out 1: high in LOAD, SHOW and GAP.

## Operation
- Reset values: state=IDLE; `mole_led`=0, `score`=0, `misses`=0, `game_over`=0, `busy`=0; prev_idx=0; button history=0.
- Edge detect: `press[i] = button[i] & ~button_q[i]`. `button_q` registers every cycle in every state.
- IDLE: LEDs off. `start`=1 → LOAD, and `score`, `misses` and the mole count clear.
- LOAD, one cycle:
  - idx = `rnd`; if `rnd`==prev_idx, idx = `rnd`+1 mod 8.
  - Latch idx into prev_idx, load show counter = `SHOW_TICKS`, mole count +1, go to SHOW.
- SHOW: `mole_led` = one-hot(idx).
  - `press[idx]` → `score`+1, saturating at 63; go to GAP.
  - Else, `tick` with show counter==1 → `misses`+1; go to GAP.
  - Else, `tick` → show counter −1.
  - On entry to GAP the gap counter loads `GAP_TICKS`.
- GAP: LEDs off. When `tick` arrives with gap counter==1:
  - `misses`==`MISS_LIMIT` or mole count==`ROUND_MOLES` → OVER.
  - Otherwise → LOAD.
- OVER: `mole_led`=8'hFF, `game_over`=1; `score` and `misses` hold. `start`=1 → LOAD, with the same clears as from IDLE.
- Priority in SHOW: hit beats timeout in the same cycle. A correct press in the same cycle as wrong presses counts as a hit.
- Presses outside SHOW are ignored; an edge is never queued.
- Held button: a single press can score only once. A button already held when SHOW begins does not score until it is released and pressed again.
- Reset asserted mid-game: immediate return to the reset values, no partial score retained.

## Timing
- `start` sampled in cycle N → `busy`=1 from N+1 (LOAD) → mole LED lit from N+2 (SHOW).
- Button rising edge in cycle N during SHOW → `score` updated and LED off at N+1.
- Mole visible for exactly `SHOW_TICKS` tick pulses when not hit. The first tick may be partial, since ticks are not aligned to SHOW entry.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `MOLE_WRONG_PENALTY_EN` defined: in SHOW, a press on any button other than idx, with no correct press in the same cycle, counts as a miss (`misses`+1) and goes to GAP immediately.
- `MOLE_WRONG_PENALTY_EN` undefined: wrong-button presses are ignored.

## Test plan
1. Hit: reset, `start` pulse, `rnd`=5 → LOAD then `mole_led`=8'h20. Press button[5] → next cycle `score`=1, `mole_led`=0, state GAP.
2. Timeout: SHOW_TICKS=8, no press, 8 ticks → `misses`=1, LEDs off. Repeat with MISS_LIMIT=3 → after 3rd gap `game_over`=1, `mole_led`=8'hFF, `busy`=0.
3. Repeat avoidance: `rnd` held at 3 across two LOADs → moles at idx 3 then idx 4 (`mole_led` 8'h08 then 8'h10). `rnd`=7 repeated → 7 then 0.
4. Simultaneous events: press[idx] in the same cycle as the expiring tick → `score`+1, `misses` unchanged. Button held from GAP into SHOW → no score until released and re-pressed.
5. Wrong press: idx=2, press button[6] → with `MOLE_WRONG_PENALTY_EN` `misses`=1 next cycle; without it the state stays SHOW and the LED stays lit.
6. Saturation and reset: ROUND_MOLES=63 and 64+ forced hits via preset → `score` stays 63. Assert `reset` mid-SHOW → all outputs 0 and IDLE within the same cycle (async).

Source files
------------

// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: round sequencer for the whack-a-mole game.
// Chooses where each mole appears, times its visibility and the dark gap with
// a shared tick down-counter, detects hits and misses, and keeps the score.
// Optional build macro: MOLE_WRONG_PENALTY_EN -- when defined, a press on a
// wrong button (with no correct press in the same cycle) counts as a miss.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | after reset, LEDs off, waiting for start
// LOAD  | one cycle: pick the mole index, load the show counter
// SHOW  | mole lit, waiting for a hit or the show counter to expire
// GAP   | LEDs off for GAP_TICKS ticks, then next mole or game over
// OVER  | all LEDs on, score/misses frozen, waiting for start
module mole_round_ctrl #(
    parameter int SHOW_TICKS  = 8,
    parameter int GAP_TICKS   = 2,
    parameter int MISS_LIMIT  = 3,
    parameter int ROUND_MOLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [2:0] rnd,
    input  logic [7:0] button,
    output logic [7:0] mole_led,
    output logic [5:0] score,
    output logic [2:0] misses,
    output logic       game_over,
    output logic       busy
);

    localparam logic [7:0] SHOW_LD   = 8'(SHOW_TICKS);
    localparam logic [7:0] GAP_LD    = 8'(GAP_TICKS);
    localparam logic [2:0] MISS_LIM  = 3'(MISS_LIMIT);
    localparam logic [5:0] ROUND_LIM = 6'(ROUND_MOLES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SHOW = 3'd2,
        S_GAP  = 3'd3,
        S_OVER = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_n;

    logic [7:0] r_button_q;
    logic [7:0] w_press;

    // r_idx is both the current mole index and the "previous index" used for
    // repeat avoidance: it is only rewritten in LOAD.
    logic [2:0] r_idx;
    logic [2:0] w_idx_n;
    logic [2:0] w_load_idx;

    logic [7:0] r_tick_cnt;
    logic [7:0] w_tick_cnt_n;
    logic       w_tick_tc;

    logic [5:0] r_mole_cnt;
    logic [5:0] w_mole_cnt_n;
    logic [5:0] r_score;
    logic [5:0] w_score_n;
    logic [5:0] w_score_inc;
    logic [2:0] r_misses;
    logic [2:0] w_misses_n;
    logic [2:0] w_misses_inc;

    logic [7:0] r_mole_led;
    logic [7:0] w_mole_led_n;
    logic       r_game_over;
    logic       r_busy;
    logic       w_hit;

`ifdef MOLE_WRONG_PENALTY_EN
    logic [7:0] w_idx_onehot;
    logic       w_wrong;
`endif

    // Rising-edge detect on the already-synchronised buttons. A button held
    // into SHOW has button_q set, so it cannot score until re-pressed.
    assign w_press      = button & ~r_button_q;
    assign w_hit        = w_press[r_idx];
    assign w_tick_tc    = tick && (r_tick_cnt == 8'd1);
    assign w_load_idx   = (rnd == r_idx) ? (rnd + 3'd1) : rnd;
    assign w_score_inc  = (r_score == 6'd63) ? r_score : (r_score + 6'd1);
    assign w_misses_inc = (r_misses == 3'd7) ? r_misses : (r_misses + 3'd1);

`ifdef MOLE_WRONG_PENALTY_EN
    assign w_idx_onehot = 8'd1 << r_idx;
    assign w_wrong      = |(w_press & ~w_idx_onehot);
`endif

    // Button history, updated every cycle regardless of state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_button_q <= 8'd0;
        end else begin
            r_button_q <= button;
        end
    end

    // Next-state and next-datapath decisions.
    always_comb begin
        w_state_n    = r_state;
        w_idx_n      = r_idx;
        w_tick_cnt_n = r_tick_cnt;
        w_mole_cnt_n = r_mole_cnt;
        w_score_n    = r_score;
        w_misses_n   = r_misses;

        case (r_state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    w_state_n    = S_LOAD;
                    w_score_n    = 6'd0;
                    w_misses_n   = 3'd0;
                    w_mole_cnt_n = 6'd0;
                end
            end

            S_LOAD: begin
                w_idx_n      = w_load_idx;
                w_tick_cnt_n = SHOW_LD;
                w_mole_cnt_n = r_mole_cnt + 6'd1;
                w_state_n    = S_SHOW;
            end

            S_SHOW: begin
                // A correct press always wins over a wrong press or timeout.
                if (w_hit) begin
                    w_score_n    = w_score_inc;
                    w_tick_cnt_n = GAP_LD;
                    w_state_n    = S_GAP;
`ifdef MOLE_WRONG_PENALTY_EN
                end else if (w_wrong) begin
                    w_misses_n   = w_misses_inc;
                    w_tick_cnt_n = GAP_LD;
                    w_state_n    = S_GAP;
`endif
                end else if (w_tick_tc) begin
                    w_misses_n   = w_misses_inc;
                    w_tick_cnt_n = GAP_LD;
                    w_state_n    = S_GAP;
                end else if (tick) begin
                    w_tick_cnt_n = r_tick_cnt - 8'd1;
                end
            end

            S_GAP: begin
                if (w_tick_tc) begin
                    if ((r_misses == MISS_LIM) || (r_mole_cnt == ROUND_LIM)) begin
                        w_state_n = S_OVER;
                    end else begin
                        w_state_n = S_LOAD;
                    end
                end else if (tick) begin
                    w_tick_cnt_n = r_tick_cnt - 8'd1;
                end
            end

            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // LED pattern derived from the state being entered, so it is registered
    // together with the state and has no input-to-output path.
    always_comb begin
        w_mole_led_n = 8'd0;
        case (w_state_n)
            S_SHOW:  w_mole_led_n = 8'd1 << w_idx_n;
            S_OVER:  w_mole_led_n = 8'hFF;
            default: w_mole_led_n = 8'd0;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= 3'd0;
            r_tick_cnt  <= 8'd0;
            r_mole_cnt  <= 6'd0;
            r_score     <= 6'd0;
            r_misses    <= 3'd0;
            r_mole_led  <= 8'd0;
            r_game_over <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_idx       <= w_idx_n;
            r_tick_cnt  <= w_tick_cnt_n;
            r_mole_cnt  <= w_mole_cnt_n;
            r_score     <= w_score_n;
            r_misses    <= w_misses_n;
            r_mole_led  <= w_mole_led_n;
            r_game_over <= (w_state_n == S_OVER);
            r_busy      <= (w_state_n == S_LOAD) || (w_state_n == S_SHOW) ||
                           (w_state_n == S_GAP);
        end
    end

    assign mole_led  = r_mole_led;
    assign score     = r_score;
    assign misses    = r_misses;
    assign game_over = r_game_over;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Testbench for mole_round_ctrl. Game-level reference model: score, misses,
// mole count and previous index are tracked as plain integers and every
// observable output is compared against them.
module tb_mole_round_ctrl;

    localparam int SHOW_T = 8;
    localparam int GAP_T  = 2;
    localparam int MISS_L = 3;
    localparam int ROUND_M = 63;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [2:0] rnd = 3'd0;
    logic [7:0] button = 8'd0;
    logic [7:0] mole_led;
    logic [5:0] score;
    logic [2:0] misses;
    logic       game_over;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    int m_score  = 0;
    int m_misses = 0;
    int m_count  = 0;
    int m_prev   = 0;

    mole_round_ctrl #(
        .SHOW_TICKS (SHOW_T),
        .GAP_TICKS  (GAP_T),
        .MISS_LIMIT (MISS_L),
        .ROUND_MOLES(ROUND_M)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .start    (start),
        .rnd      (rnd),
        .button   (button),
        .mole_led (mole_led),
        .score    (score),
        .misses   (misses),
        .game_over(game_over),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] led_e,
                              input logic busy_e, input logic go_e);
        chk({tag, ".led"},    {24'd0, mole_led},      {24'd0, led_e});
        chk({tag, ".busy"},   {31'd0, busy},          {31'd0, busy_e});
        chk({tag, ".over"},   {31'd0, game_over},     {31'd0, go_e});
        chk({tag, ".score"},  {26'd0, score},         m_score);
        chk({tag, ".misses"}, {29'd0, misses},        m_misses);
    endtask

    // From IDLE or OVER: raise start for one cycle, land in LOAD.
    task automatic begin_game();
        start = 1'b1;
        cyc();
        start = 1'b0;
        m_score  = 0;
        m_misses = 0;
        m_count  = 0;
        check_outs("start", 8'h00, 1'b1, 1'b0);
    endtask

    // In LOAD: present rnd, optionally hold the future mole's button.
    task automatic load_mole(input int r, input bit held, output int idx);
        idx = (r == m_prev) ? (r + 1) % 8 : r;
        m_prev = idx;
        m_count++;
        rnd = 3'(r);
        if (held) button = 8'(1 << idx);
        cyc();
        rnd = 3'($urandom_range(0, 7));
        check_outs("show", 8'(1 << idx), 1'b1, 1'b0);
    endtask

    // In SHOW: wait (random or until the final tick), then hit.
    task automatic show_hit(input int idx, input bit late);
        int t = 0;
        int w;
        w = late ? SHOW_T - 1 : $urandom_range(0, 4);
        while (w > 0 || (late && t < SHOW_T - 1)) begin
            if (late) tick = 1'b1;
            else      tick = (t < SHOW_T - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (tick) t++;
            cyc();
            tick = 1'b0;
            chk("wait.led", {24'd0, mole_led}, 1 << idx);
            if (w > 0) w--;
        end
        button = 8'($urandom_range(0, 255)) | 8'(1 << idx);
        tick = late ? 1'b1 : 1'($urandom_range(0, 1));
        cyc();
        button = 8'd0;
        tick = 1'b0;
        m_score = (m_score < 63) ? m_score + 1 : 63;
        check_outs("hit", 8'h00, 1'b1, 1'b0);
    endtask

    // In SHOW: let the mole expire after exactly SHOW_T ticks.
    task automatic show_timeout(input int idx);
        for (int t = 0; t < SHOW_T; t++) begin
            repeat ($urandom_range(0, 1)) begin
                tick = 1'b0;
                cyc();
            end
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            if (t < SHOW_T - 1) begin
                chk("tmo.lit", {24'd0, mole_led}, 1 << idx);
            end else begin
                m_misses++;
                check_outs("timeout", 8'h00, 1'b1, 1'b0);
            end
        end
    endtask

    // In SHOW: press a single wrong button. Returns 1 if the mole ended.
    task automatic show_wrong(input int idx, output bit ended);
        int w;
        w = (idx + $urandom_range(1, 7)) % 8;
        button = 8'(1 << w);
        tick = 1'b0;
        cyc();
        button = 8'd0;
`ifdef MOLE_WRONG_PENALTY_EN
        m_misses++;
        ended = 1'b1;
        check_outs("wrong", 8'h00, 1'b1, 1'b0);
`else
        ended = 1'b0;
        check_outs("wrong", 8'(1 << idx), 1'b1, 1'b0);
`endif
    endtask

    // In GAP: stray presses are ignored; after GAP_T ticks -> LOAD or OVER.
    task automatic gap_phase(output bit over);
        for (int t = 0; t < GAP_T; t++) begin
            repeat ($urandom_range(0, 2)) begin
                tick = 1'b0;
                button = 8'($urandom_range(0, 255));
                cyc();
                check_outs("gap", 8'h00, 1'b1, 1'b0);
            end
            button = 8'd0;
            tick = 1'b1;
            cyc();
            tick = 1'b0;
        end
        over = (m_misses == MISS_L) || (m_count == ROUND_M);
        if (over) check_outs("over", 8'hFF, 1'b0, 1'b1);
        else      check_outs("next", 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        int  idx;
        bit  over;
        bit  ended;

        // Reset state
        repeat (2) cyc();
        check_outs("reset", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        cyc();

        // Presses in IDLE do nothing
        button = 8'hFF;
        cyc();
        button = 8'h00;
        cyc();
        check_outs("idle", 8'h00, 1'b0, 1'b0);

        // Game 1: hit, repeat avoidance, simultaneous, held, wrong, miss limit
        begin_game();
        load_mole(5, 1'b0, idx);
        chk("first.idx", {24'd0, mole_led}, 32'h20);
        show_hit(idx, 1'b0);
        gap_phase(over);

        load_mole(3, 1'b0, idx);
        chk("rep3a", {24'd0, mole_led}, 32'h08);
        show_hit(idx, 1'b0);
        gap_phase(over);
        load_mole(3, 1'b0, idx);
        chk("rep3b", {24'd0, mole_led}, 32'h10);
        show_hit(idx, 1'b0);
        gap_phase(over);

        load_mole(7, 1'b0, idx);
        chk("rep7a", {24'd0, mole_led}, 32'h80);
        show_timeout(idx);
        gap_phase(over);
        load_mole(7, 1'b0, idx);
        chk("rep7b", {24'd0, mole_led}, 32'h01);
        show_hit(idx, 1'b1);
        gap_phase(over);

        load_mole($urandom_range(0, 7), 1'b1, idx);
        repeat (2) begin
            cyc();
            check_outs("held", 8'(1 << idx), 1'b1, 1'b0);
        end
        button = 8'd0;
        cyc();
        check_outs("release", 8'(1 << idx), 1'b1, 1'b0);
        show_hit(idx, 1'b0);
        gap_phase(over);

        load_mole(2, 1'b0, idx);
        show_wrong(idx, ended);
        if (!ended) show_timeout(idx);
        gap_phase(over);

        load_mole($urandom_range(0, 7), 1'b0, idx);
        show_timeout(idx);
        gap_phase(over);
        chk("g1.over", {31'd0, over}, 32'd1);

        // OVER holds while start is low
        repeat (3) begin
            button = 8'($urandom_range(0, 255));
            cyc();
            check_outs("hold", 8'hFF, 1'b0, 1'b1);
        end
        button = 8'd0;
        cyc();

        // Game 2: three timeouts from OVER
        begin_game();
        over = 1'b0;
        for (int k = 0; k < 3; k++) begin
            load_mole($urandom_range(0, 7), 1'b0, idx);
            show_timeout(idx);
            gap_phase(over);
        end
        chk("g2.over", {31'd0, over}, 32'd1);
        cyc();

        // Game 3: full round of ROUND_M random hits, score tops out at 63
        begin_game();
        over = 1'b0;
        for (int k = 0; k < ROUND_M && !over; k++) begin
            load_mole($urandom_range(0, 7), 1'b0, idx);
            show_hit(idx, 1'($urandom_range(0, 3) == 0));
            gap_phase(over);
        end
        chk("g3.over", {31'd0, over}, 32'd1);
        chk("g3.score", {26'd0, score}, 32'd63);
        cyc();

        // Game 4: async reset in the middle of SHOW
        begin_game();
        load_mole($urandom_range(0, 7), 1'b0, idx);
        cyc();
        #2;
        reset = 1'b1;
        #1;
        m_score  = 0;
        m_misses = 0;
        m_count  = 0;
        m_prev   = 0;
        check_outs("async", 8'h00, 1'b0, 1'b0);
        cyc();
        reset = 1'b0;
        cyc();
        check_outs("post", 8'h00, 1'b0, 1'b0);
        begin_game();
        load_mole(0, 1'b0, idx);
        chk("prev.clr", {24'd0, mole_led}, 32'h02);
        show_hit(idx, 1'b0);
        gap_phase(over);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
